// File: rtl/hdmi_video_pkg.sv
// hdmi_video_pkg: 1080p raster timing, black YCbCr pixel and stream-lock states
// shared by the AXIS-to-HDMI video path.
package hdmi_video_pkg;
    localparam int H_ACTIVE_1080 = 1920;
    localparam int H_FP_1080     = 88;
    localparam int H_SYNC_1080   = 44;
    localparam int H_BP_1080     = 148;
    localparam int V_ACTIVE_1080 = 1080;
    localparam int V_FP_1080     = 4;
    localparam int V_SYNC_1080   = 5;
    localparam int V_BP_1080     = 36;
    localparam logic [15:0] BLANK_YCBCR = 16'h8010;
    typedef enum logic [1:0] {WAIT_SOF, WAIT_FRAME, RUN} state_t;
endpackage

// File: rtl/video_timing_gen.sv
// video_timing_gen: free-running raster counters with combinational blanking,
// sync and position decode; the caller registers whatever it forwards.
module video_timing_gen
    import hdmi_video_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_1080,
    parameter int H_FP     = H_FP_1080,
    parameter int H_SYNC   = H_SYNC_1080,
    parameter int H_BP     = H_BP_1080,
    parameter int V_ACTIVE = V_ACTIVE_1080,
    parameter int V_FP     = V_FP_1080,
    parameter int V_SYNC   = V_SYNC_1080,
    parameter int V_BP     = V_BP_1080
) (
    input  logic clk,
    input  logic rstn,
    output logic hb,
    output logic vb,
    output logic de,
    output logic hs,
    output logic vs,
    output logic sof_pos,
    output logic eof_pos,
    output logic eol_pos
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_ACT = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_EOL = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_HS0 = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_HS1 = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_END = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_VS0 = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_VS1 = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_END = VW'(V_TOTAL - 1);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_END) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_END) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign hb      = h_cnt >= H_ACT;
    assign vb      = v_cnt >= V_ACT;
    assign de      = !hb && !vb;
    assign hs      = h_cnt >= H_HS0 && h_cnt < H_HS1;
    assign vs      = v_cnt >= V_VS0 && v_cnt < V_VS1;
    assign sof_pos = h_cnt == '0 && v_cnt == '0;
    assign eof_pos = h_cnt == H_END && v_cnt == V_END;
    assign eol_pos = h_cnt == H_EOL;
endmodule

// File: rtl/axis_to_hdmi_video.sv
// axis_to_hdmi_video: locks an AXIS VDMA pixel stream to a free-running raster
// and emits registered HDMI timing plus pixel data, blanking on any loss of sync.
import hdmi_video_pkg::*;

module axis_to_hdmi_video #(
    parameter int AXIS_DATA_WIDTH = 16,
    parameter int H_ACTIVE = H_ACTIVE_1080,
    parameter int H_FP     = H_FP_1080,
    parameter int H_SYNC   = H_SYNC_1080,
    parameter int H_BP     = H_BP_1080,
    parameter int V_ACTIVE = V_ACTIVE_1080,
    parameter int V_FP     = V_FP_1080,
    parameter int V_SYNC   = V_SYNC_1080,
    parameter int V_BP     = V_BP_1080,
    parameter logic [AXIS_DATA_WIDTH-1:0] BLANK_DATA = BLANK_YCBCR
) (
    input  logic                       pix_clk_i,
    input  logic                       pix_rstn_i,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tuser,
    input  logic                       s_axis_tlast,
    output logic                       o_hdmi_vs,
    output logic                       o_hdmi_hs,
    output logic                       o_hdmi_vb,
    output logic                       o_hdmi_hb,
    output logic                       o_hdmi_de,
    output logic [AXIS_DATA_WIDTH-1:0] o_hdmi_dt,
    output logic                       o_locked,
    output logic                       o_underflow,
    output logic                       o_resync,
    output logic                       o_eol_err
);
    state_t state;
    logic hb, vb, de, hs, vs, sof_pos, eof_pos, eol_pos;
    logic active, sof_miss, sof_early, take;

    video_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk(pix_clk_i), .rstn(pix_rstn_i),
        .hb(hb), .vb(vb), .de(de), .hs(hs), .vs(vs),
        .sof_pos(sof_pos), .eof_pos(eof_pos), .eol_pos(eol_pos)
    );

    // A frame start off the raster origin, or a missing one on it, means the
    // stream and the raster disagree; such a beat is never consumed.
    assign active    = state == RUN && de;
    assign sof_miss  = s_axis_tvalid && sof_pos && !s_axis_tuser;
    assign sof_early = s_axis_tvalid && !sof_pos && s_axis_tuser;
    assign take      = active && s_axis_tvalid && !sof_miss && !sof_early;
    assign o_locked  = state == RUN;
    assign s_axis_tready = pix_rstn_i && (state == WAIT_SOF ? !(s_axis_tvalid && s_axis_tuser)
                                          : state == RUN && de && !sof_miss && !sof_early);

    always_ff @(posedge pix_clk_i) begin
        if (!pix_rstn_i) begin
            state <= WAIT_SOF;
            {o_hdmi_vs, o_hdmi_hs, o_hdmi_vb, o_hdmi_hb, o_hdmi_de} <= '0;
            o_hdmi_dt <= '0;
            {o_underflow, o_resync, o_eol_err} <= '0;
        end else begin
            {o_hdmi_vs, o_hdmi_hs, o_hdmi_vb, o_hdmi_hb, o_hdmi_de} <= {vs, hs, vb, hb, de};
            o_hdmi_dt   <= take ? s_axis_tdata : BLANK_DATA;
            o_underflow <= o_underflow || (active && !s_axis_tvalid);
            o_resync    <= o_resync || (active && (sof_miss || sof_early));
            o_eol_err   <= o_eol_err || (take && (s_axis_tlast != eol_pos));
            case (state)
                WAIT_SOF:   if (s_axis_tvalid && s_axis_tuser) state <= WAIT_FRAME;
                WAIT_FRAME: if (eof_pos) state <= RUN;
                default:    if (active) state <= sof_early ? WAIT_FRAME
                                                : (sof_miss || !s_axis_tvalid) ? WAIT_SOF : RUN;
            endcase
        end
    end
endmodule

// File: doc/axis_to_hdmi_video.md
AXIS_TO_HDMI_VIDEO -- requirements
Module: axis_to_hdmi_video

Interface
REQ-001 SHALL have parameter AXIS_DATA_WIDTH, default 16, pixel width (YCbCr 4:2:2, {C,Y}).
REQ-002 SHALL have parameters H_ACTIVE 1920, H_FP 88, H_SYNC 44, H_BP 148 (pixels).
REQ-003 SHALL have parameters V_ACTIVE 1080, V_FP 4, V_SYNC 5, V_BP 36 (lines).
REQ-004 SHALL have parameter BLANK_DATA, default 16'h8010, black pixel for underflow and error slots.
REQ-005 pix_clk_i  in  1  pixel clock; the only clock.
REQ-006 pix_rstn_i  in  1  reset; synchronous, active-low.
REQ-007 s_axis_tdata  in  AXIS_DATA_WIDTH  pixel from VDMA.
REQ-008 s_axis_tvalid / s_axis_tready  in / out  1  AXIS handshake.
REQ-009 s_axis_tuser  in  1  start of frame; s_axis_tlast  in  1  end of line.
REQ-010 o_hdmi_vs, o_hdmi_hs, o_hdmi_vb, o_hdmi_hb, o_hdmi_de  out  1 each  timing to HDMI TX output stage.
REQ-011 o_hdmi_dt  out  AXIS_DATA_WIDTH  pixel data, aligned with o_hdmi_de.
REQ-012 o_locked  out  1  high while state is RUN.
REQ-013 o_underflow, o_resync, o_eol_err  out  1 each  sticky error flags.

Function
REQ-014 SHALL keep h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H params = 2200), v_cnt 0..V_TOTAL-1 (1125); h wraps to 0 and increments v; v wraps at frame end.
REQ-015 Decode from counters: hb = h_cnt>=H_ACTIVE; vb = v_cnt>=V_ACTIVE; de = !hb & !vb; hs = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vs = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC); all active-high.
REQ-016 All o_hdmi_* SHALL be registered; latency exactly 1 cycle from counter value to output.
REQ-017 States WAIT_SOF, WAIT_FRAME, RUN; reset enters WAIT_SOF.
REQ-018 WAIT_SOF: tready = !(tvalid & tuser); non-SOF beats discarded; on tvalid&tuser -> WAIT_FRAME (beat not consumed).
REQ-019 WAIT_FRAME: tready=0; at h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1 -> RUN.
REQ-020 RUN: tready = de; accepted beat -> o_hdmi_dt next cycle.
REQ-021 RUN, de=1 at (0,0) with tvalid&!tuser: beat not accepted, BLANK_DATA output, o_resync set, -> WAIT_SOF.
REQ-022 RUN, de=1 at non-(0,0) with tvalid&tuser: beat not accepted, BLANK_DATA output, o_resync set, -> WAIT_FRAME.
REQ-023 RUN, de=1 and tvalid=0: BLANK_DATA output, o_underflow set, -> WAIT_SOF.
REQ-024 Accepted beat with tlast != (h_cnt==H_ACTIVE-1): o_eol_err set, no state change.
REQ-025 Outside RUN or when de=0, o_hdmi_dt = BLANK_DATA; timing outputs free-run in every state.
REQ-026 Simultaneous error conditions: REQ-022 takes priority over REQ-024.

Reset
REQ-027 While pix_rstn_i=0 at a clock edge: counters 0, state WAIT_SOF, tready 0, all o_hdmi_* 0, o_hdmi_dt 0, o_locked and all sticky flags 0.
REQ-028 Reset mid-frame SHALL abandon the frame; first cycle after release outputs counter (0,0) decode.
REQ-029 Sticky flags clear only by reset.

Structure
REQ-030 Package hdmi_video_pkg SHALL hold 1080p timing constants, BLANK_DATA, state enum.
REQ-031 Sub-module video_timing_gen SHALL own counters and REQ-015 decode; top holds FSM, handshake, output registers.

Verification
REQ-032 Reset release, tvalid=0 -> hs period 2200 cycles, 44 high; vs 5 lines every 1125 lines; de 1920 per line, 1080 lines; dt=16'h8010.
REQ-033 Full frame, tuser on first beat, tlast each 1920th, data=counter -> o_locked 1, dt equals input in order, de-aligned, no flags.
REQ-034 Stall tvalid for 1 cycle at pixel 100 of line 5 -> dt 16'h8010 that slot, o_underflow 1, state WAIT_SOF, o_locked 0.
REQ-035 tuser asserted at pixel 500 of line 10 in RUN -> beat held (tready 0), o_resync 1, output resumes at next frame (0,0) with that beat.
REQ-036 tlast at pixel 1918 -> o_eol_err 1, o_locked stays 1.
REQ-037 Reset asserted mid-line 300 for 3 cycles -> all outputs 0, then counters restart at (0,0), state WAIT_SOF.
